// File: rtl/bcd_adder_if.sv
// -----------------------------------------------------------------------------
// bcd_adder_if
//   Operand/result bundle for one decimal digit stage.
//
//   A    [3:0]  addend digit (nominally 0-9, any value accepted)
//   B    [3:0]  addend digit (nominally 0-9, any value accepted)
//   Cin         decimal carry-in
//   Sum  [7:0]  packed BCD result: [7:4] tens digit, [3:0] units digit
//   err         operand out of BCD range flag
//
//   master: drives operands, observes result (datapath / testbench side)
//   slave : consumes operands, drives result (the adder itself)
// -----------------------------------------------------------------------------
interface bcd_adder_if;
    logic [3:0] A;
    logic [3:0] B;
    logic       Cin;
    logic [7:0] Sum;
    logic       err;

    modport master (
        output A,
        output B,
        output Cin,
        input  Sum,
        input  err
    );

    modport slave (
        input  A,
        input  B,
        input  Cin,
        output Sum,
        output err
    );
endinterface : bcd_adder_if

// File: rtl/bcd_adder.sv
// -----------------------------------------------------------------------------
// bcd_adder
//   Single-digit BCD adder with registered output. Adds two 4-bit digits and a
//   carry-in, and presents the total as a two-digit packed BCD value one clock
//   after the operands are sampled. Non-BCD operands are still summed exactly
//   (tens digit may reach 3) and are reported on err.
//
//   clk        rising-edge clock
//   rst        synchronous, active-high reset; clears Sum and err
//   bus.A/B    addend digits
//   bus.Cin    decimal carry-in
//   bus.Sum    registered packed BCD result
//   bus.err    registered flag: A > 9 or B > 9 in the sampled operands
// -----------------------------------------------------------------------------
module bcd_adder (
    input  logic         clk,
    input  logic         rst,
    bcd_adder_if.slave   bus
);

    logic [4:0] total;     // binary A + B + Cin, 0..31
    logic [1:0] tens;      // T / 10, 0..3
    logic [4:0] rem;       // T % 10, always < 10 after correction
    logic [3:0] units;
    logic       bad_digit;

    // Widen before adding so the carry out of the 4-bit operands is kept.
    assign total = {1'b0, bus.A} + {1'b0, bus.B} + {4'b0000, bus.Cin};

    // Divide by ten with a threshold ladder: the total never exceeds 31, so
    // the tens digit is one of four values and no general divider is needed.
    // For T <= 19 this reduces to the classic "add 6 when above 9" correction.
    // NOTE: every output of a combinational block gets a default first so that
    // no path leaves it unassigned and a latch cannot be inferred.
    always_comb begin
        tens = 2'd0;
        rem  = total;
        if (total >= 5'd30) begin
            tens = 2'd3;
            rem  = total - 5'd30;
        end else if (total >= 5'd20) begin
            tens = 2'd2;
            rem  = total - 5'd20;
        end else if (total >= 5'd10) begin
            tens = 2'd1;
            rem  = total - 5'd10;
        end
    end

    assign units     = rem[3:0];
    assign bad_digit = (bus.A > 4'd9) || (bus.B > 4'd9);

    // Reset takes priority over capture; the operand in flight is dropped.
    // NOTE: registers are updated with non-blocking assignments so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.Sum <= 8'h00;
            bus.err <= 1'b0;
        end else begin
            bus.Sum <= {2'b00, tens, units};
            bus.err <= bad_digit;
        end
    end

endmodule : bcd_adder

// File: tb/tb_bcd_adder.sv
// -----------------------------------------------------------------------------
// tb_bcd_adder
//   Self-checking bench for bcd_adder: reset behaviour, a directed vector
//   table, an exhaustive sweep against an arithmetic reference model, and a
//   mid-stream reset sequence. Operands change on the falling edge; results
//   are sampled 1 ns after the rising edge that captured them.
// -----------------------------------------------------------------------------
module tb_bcd_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;

    bcd_adder_if bus ();

    bcd_adder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       err;
    } vec_t;

    int n_tests  = 0;
    int n_failed = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Present operands before the next rising edge, then sample after it.
    task automatic step(input logic [3:0] a, input logic [3:0] b, input logic cin, input logic r);
        @(negedge clk);
        bus.A   = a;
        bus.B   = b;
        bus.Cin = cin;
        rst     = r;
        @(posedge clk);
        #1;
    endtask

    // Reference: decimal digits of the exact binary total.
    function automatic logic [7:0] ref_sum(input logic [3:0] a, input logic [3:0] b, input logic cin);
        int t;
        t = int'(a) + int'(b) + int'(cin);
        return 8'((t / 10) * 16 + (t % 10));
    endfunction

    vec_t vecs [11];

    initial begin
        vecs[0]  = '{4'd4,  4'd5,  1'b0, 8'h09, 1'b0};
        vecs[1]  = '{4'd0,  4'd0,  1'b0, 8'h00, 1'b0};
        vecs[2]  = '{4'd5,  4'd5,  1'b0, 8'h10, 1'b0};
        vecs[3]  = '{4'd4,  4'd5,  1'b1, 8'h10, 1'b0};
        vecs[4]  = '{4'd9,  4'd9,  1'b0, 8'h18, 1'b0};
        vecs[5]  = '{4'd9,  4'd9,  1'b1, 8'h19, 1'b0};
        vecs[6]  = '{4'd15, 4'd5,  1'b0, 8'h20, 1'b1};
        vecs[7]  = '{4'd15, 4'd9,  1'b0, 8'h24, 1'b1};
        vecs[8]  = '{4'd15, 4'd15, 1'b1, 8'h31, 1'b1};
        vecs[9]  = '{4'd9,  4'd9,  1'b0, 8'h18, 1'b0};
        vecs[10] = '{4'd10, 4'd0,  1'b0, 8'h10, 1'b1};

        bus.A   = 4'd9;
        bus.B   = 4'd9;
        bus.Cin = 1'b1;

        // Reset held for two edges with non-zero operands.
        for (int i = 0; i < 2; i++) begin
            step(4'd9, 4'd9, 1'b1, 1'b1);
            check($sformatf("reset_sum_%0d", i), bus.Sum, 8'h00);
            check($sformatf("reset_err_%0d", i), {7'b0, bus.err}, 8'h00);
        end

        // First edge after release captures the current operands.
        step(4'd9, 4'd9, 1'b1, 1'b0);
        check("release_sum", bus.Sum, 8'h19);
        check("release_err", {7'b0, bus.err}, 8'h00);

        // Directed table.
        foreach (vecs[i]) begin
            step(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0);
            check($sformatf("vec%0d_sum", i), bus.Sum, vecs[i].sum);
            check($sformatf("vec%0d_err", i), {7'b0, bus.err}, {7'b0, vecs[i].err});
        end

        // Exhaustive sweep, one operation per cycle.
        for (int i = 0; i < 512; i++) begin
            logic [3:0] a;
            logic [3:0] b;
            logic       c;
            a = 4'(i >> 5);
            b = 4'(i >> 1);
            c = i[0];
            step(a, b, c, 1'b0);
            check($sformatf("exh_sum a=%0d b=%0d c=%0d", a, b, c), bus.Sum, ref_sum(a, b, c));
            check($sformatf("exh_err a=%0d b=%0d c=%0d", a, b, c), {7'b0, bus.err},
                  {7'b0, (a > 4'd9) || (b > 4'd9)});
        end

        // Mid-stream reset: a bad value first so the clear is visible on err too.
        step(4'd12, 4'd8, 1'b0, 1'b0);
        check("mid_pre_sum", bus.Sum, 8'h20);
        check("mid_pre_err", {7'b0, bus.err}, 8'h01);
        step(4'd7, 4'd8, 1'b0, 1'b1);
        check("mid_rst_sum", bus.Sum, 8'h00);
        check("mid_rst_err", {7'b0, bus.err}, 8'h00);
        step(4'd7, 4'd8, 1'b0, 1'b0);
        check("mid_post_sum", bus.Sum, 8'h15);
        check("mid_post_err", {7'b0, bus.err}, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish before 200000 ns");
        $fatal(1, "timeout");
    end

endmodule : tb_bcd_adder
